mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Sequences a single-port, variable-latency unified memory shared by the single-cycle CPU's instruction fetch and its load/store path. Arbitrates between the two requesters, with data winning. Drives byte lanes from DMType, sign/zero-extends load data, and returns results with a one-cycle valid pulse. A stall output freezes the CPU (PC and register write) until its outstanding accesses complete.

Parameters:
ADDR_W, 32, byte address width
TIMEOUT, 16, max cycles waiting for mem_ready before abort (>=2)
CNT_W, 5, width of wait counter (must hold TIMEOUT)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
if_req  in  1  fetch request, held until if_valid
if_addr  in  ADDR_W  fetch byte address (PC)
if_rdata  out  32  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
d_req  in  1  load/store request, held until d_valid
d_we  in  1  1 = store
d_type  in  3  DMType: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
d_addr  in  ADDR_W  data byte address (ALU result)
d_wdata  in  32  store data (rs2)
d_rdata  out  32  extended load data
d_valid  out  1  one-cycle data completion pulse
misalign  out  1  pulse with valid: access rejected for alignment
bus_err  out  1  pulse with valid: access aborted by timeout
stall  out  1  CPU must hold state
mem_req  out  1  memory access strobe
mem_we  out  1  memory write
mem_be  out  4  byte enables
mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  memory read word
mem_ready  in  1  memory completes access this cycle

Behaviour:
- Reset (rst==0 at posedge): state IDLE, counter 0. All outputs 0: if_rdata, d_rdata, valids, misalign, bus_err, mem_* registers.
- Reset mid-access drops the access. No valid is produced.
- FSM states: IDLE, FETCH, DATA, DONE.
- IDLE:
  - d_req && !d_valid has priority → DATA.
  - Otherwise if_req && !if_valid → FETCH.
  - Address, we, type and wdata are latched on entry.
- Alignment check at grant:
  - Word needs addr[1:0]==0. Half needs addr[0]==0. Fetch is always word.
  - A violating access goes to DONE without asserting mem_req: misalign=1, rdata=0, no write.
- FETCH/DATA:
  - mem_req=1; mem_addr, mem_we, mem_be, mem_wdata are driven from latched values and stay stable until mem_ready.
  - Counter increments each cycle mem_ready=0.
  - mem_ready=1: capture the read data (extended for DATA), go to DONE.
  - Counter reaches TIMEOUT-1 with mem_ready=0: abort, bus_err=1, rdata=0, go to DONE.
- DONE: assert the corresponding valid (plus misalign/bus_err if set) for exactly one cycle, clear the counter, return to IDLE. mem_req=0 in DONE.
- Minimum latency with zero-wait memory: grant cycle t, mem_req at t+1, valid at t+2.
- Byte enables and write data:
  - Word: be=1111.
  - Half: be=0011 or 1100 by addr[1], wdata={2{d_wdata[15:0]}}.
  - Byte: be=0001<<addr[1:0], wdata={4{d_wdata[7:0]}}.
  - Loads: mem_we=0, be=1111.
- Load extraction uses latched addr[1:0]: half selects [15:0] or [31:16]; byte selects lane addr[1:0]. Sign-extend types 001/011, zero-extend 010/100.
- stall = (d_req && !d_valid) || (if_req && !if_valid). It is combinational and drops in the valid cycle.
- A requester deasserting before valid is illegal. Behaviour is undefined; the bench does not test it.
- Simultaneous requests in IDLE: data is served first. Fetch is granted on the IDLE cycle after DONE.
- valid pulses never overlap; at most one access is outstanding.

Test Plan:
- Zero-wait fetch: mem_ready tied 1, if_addr=0x0000_0010, mem_rdata=0x0051_8533 → mem_addr=0x10 at t+1, if_valid at t+2, if_rdata=0x0051_8533, stall 1 for t..t+1.
- Store byte: d_we=1, d_type=011, d_addr=0x103, d_wdata=0xAABBCCDD → mem_be=1000, mem_wdata=0xDDDDDDDD, mem_addr=0x100.
- Load half signed/unsigned at 0x102, mem_rdata=0x8001_7FFF → type 001 gives d_rdata=0xFFFF_8001; type 010 gives 0x0000_8001.
- Simultaneous if_req and d_req, 2 wait states → DATA access first (d_valid at t+4), then FETCH; if_valid 3 cycles after DATA valid with zero wait.
- Misaligned word load at 0x0000_0006 → no mem_req, d_valid and misalign pulse at t+1, d_rdata=0; mem_ready never 1 for TIMEOUT=16 → bus_err and d_valid 16 cycles after mem_req rises.
- Reset: rst=0 during DATA wait → next cycle state IDLE, mem_req=0, no d_valid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for a single-port, variable-latency memory shared by
// instruction fetch and load/store; data wins, results return as one-cycle valid pulses.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_type,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              misalign,
  output logic              bus_err,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises *_req and holds it (with stable operands) until
  // the matching *_valid pulse; the pulse lasts exactly one cycle and completes it.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt;
  logic             lat_is_data;
  logic [2:0]       lat_type;
  logic [1:0]       lat_off;

  logic             grant_d, grant_f, acc_ok, acc_timeout;
  logic             d_is_half, d_is_byte, d_aligned, f_aligned;
  logic [3:0]       store_be;
  logic [31:0]      store_wdata;
  logic [31:0]      load_ext;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  assign d_is_half = (d_type == 3'b001) || (d_type == 3'b010);
  assign d_is_byte = (d_type == 3'b011) || (d_type == 3'b100);
  assign d_aligned = d_is_byte ? 1'b1 :
                     d_is_half ? ~d_addr[0] : (d_addr[1:0] == 2'b00);
  assign f_aligned = (if_addr[1:0] == 2'b00);

  assign stall     = (d_req && !d_valid) || (if_req && !if_valid);
  assign dbg_state = state_q;

  // Store lanes: narrow data is replicated so the enabled lane always sees it.
  always_comb begin
    store_be    = 4'b1111;
    store_wdata = d_wdata;
    if (d_is_half) begin
      store_be    = d_addr[1] ? 4'b1100 : 4'b0011;
      store_wdata = {2{d_wdata[15:0]}};
    end else if (d_is_byte) begin
      store_be    = 4'b0001 << d_addr[1:0];
      store_wdata = {4{d_wdata[7:0]}};
    end
  end

  always_comb begin
    lane_b = mem_rdata[7:0];
    case (lat_off)
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      2'd3:    lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_type)
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_ext = {16'h0000, lane_h};
      3'b011:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_ext = {24'h000000, lane_b};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = 1'b0;
    grant_f     = 1'b0;
    acc_ok      = 1'b0;
    acc_timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (d_req && !d_valid) begin
          grant_d = 1'b1;
          state_d = d_aligned ? S_DATA : S_DONE;
        end else if (if_req && !if_valid) begin
          grant_f = 1'b1;
          state_d = f_aligned ? S_FETCH : S_DONE;
        end
      end
      S_FETCH, S_DATA: begin
        if (mem_ready) begin
          acc_ok  = 1'b1;
          state_d = S_DONE;
        end else if (wait_cnt == TO_LAST) begin
          acc_timeout = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt    <= '0;
      lat_is_data <= 1'b0;
      lat_type    <= 3'b000;
      lat_off     <= 2'b00;
      if_rdata    <= 32'h0;
      if_valid    <= 1'b0;
      d_rdata     <= 32'h0;
      d_valid     <= 1'b0;
      misalign    <= 1'b0;
      bus_err     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 4'b0000;
      mem_addr    <= '0;
      mem_wdata   <= 32'h0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;

      if (acc_ok || acc_timeout || state_q == S_DONE)
        wait_cnt <= '0;
      else if ((state_q == S_FETCH || state_q == S_DATA) && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;

      if (grant_d) begin
        lat_is_data <= 1'b1;
        lat_type    <= d_type;
        lat_off     <= d_addr[1:0];
        if (d_aligned) begin
          mem_req   <= 1'b1;
          mem_we    <= d_we;
          mem_addr  <= {d_addr[ADDR_W-1:2], 2'b00};
          mem_be    <= d_we ? store_be : 4'b1111;
          mem_wdata <= store_wdata;
        end else begin
          d_valid  <= 1'b1;
          misalign <= 1'b1;
          d_rdata  <= 32'h0;
        end
      end

      if (grant_f) begin
        lat_is_data <= 1'b0;
        lat_type    <= 3'b000;
        lat_off     <= 2'b00;
        if (f_aligned) begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
          mem_be    <= 4'b1111;
          mem_wdata <= 32'h0;
        end else begin
          if_valid <= 1'b1;
          misalign <= 1'b1;
          if_rdata <= 32'h0;
        end
      end

      // A timed-out access returns zero data and flags bus_err alongside its valid.
      if (acc_ok || acc_timeout) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        bus_err <= acc_timeout;
        if (lat_is_data) begin
          d_valid <= 1'b1;
          d_rdata <= acc_ok ? load_ext : 32'h0;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= acc_ok ? mem_rdata : 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model predicts memory
// strobes, result data and latency; a negedge compare process checks every cycle.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0]  d_type = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, misalign, bus_err, stall, mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .misalign(misalign), .bus_err(bus_err),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic int nbytes(input logic [2:0] t);
    if (t == 3'b001 || t == 3'b010) return 2;
    if (t == 3'b011 || t == 3'b100) return 1;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic we, input logic [2:0] t, input logic [31:0] a);
    int nb;
    nb = nbytes(t);
    if (!we) return 4'hF;
    return 4'(((1 << nb) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] t, input logic [31:0] wd);
    int nb;
    nb = nbytes(t);
    if (nb == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (nb == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] word);
    int nb;
    logic [63:0] mask, v;
    nb   = nbytes(t);
    mask = (64'd1 << (8 * nb)) - 64'd1;
    v    = ({32'h0, word} >> (8 * (a % 4))) & mask;
    if ((t == 3'b001 || t == 3'b011) && v[8*nb-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [7:0]  waits;
    logic [31:0] word;
  } mem_exp_t;

  mem_exp_t    mem_q[$];
  logic [34:0] exp_q[$];  // {is_data, misalign, bus_err, rdata}

  // ---------------- memory responder ----------------
  int          wcnt = 0;
  bit          in_acc = 0;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_we;

  always @(negedge clk) begin
    if (!mem_req) begin
      if (in_acc && mem_q.size() > 0) mem_q.delete(0);
      in_acc    = 0;
      wcnt      = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end else if (mem_q.size() == 0) begin
      check("mem_req_unexpected", {31'h0, mem_req}, 32'h0);
      mem_ready = 1'b1;
    end else begin
      in_acc     = 1;
      last_addr  = mem_addr;
      last_be    = mem_be;
      last_we    = mem_we;
      last_wdata = mem_wdata;
      check("mem_addr", mem_addr, mem_q[0].addr);
      check("mem_be", {28'h0, mem_be}, {28'h0, mem_q[0].be});
      check("mem_we", {31'h0, mem_we}, {31'h0, mem_q[0].we});
      if (mem_q[0].we) check("mem_wdata", mem_wdata, mem_q[0].wdata);
      if (wcnt == int'(mem_q[0].waits)) begin
        mem_ready = 1'b1;
        mem_rdata = mem_q[0].word;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        wcnt++;
      end
    end
  end

  // ---------------- result scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("stall", {31'h0, stall},
            {31'h0, (d_req && !d_valid) || (if_req && !if_valid)});
      check("valid_overlap", {31'h0, if_valid & d_valid}, 32'h0);
      if (if_valid || d_valid) begin
        if (exp_q.size() == 0) begin
          check("valid_unexpected", {30'h0, if_valid, d_valid}, 32'h0);
        end else begin
          logic [34:0] e;
          e = exp_q.pop_front();
          check("valid_kind", {31'h0, d_valid}, {31'h0, e[34]});
          check("misalign", {31'h0, misalign}, {31'h0, e[33]});
          check("bus_err", {31'h0, bus_err}, {31'h0, e[32]});
          check(e[34] ? "d_rdata" : "if_rdata", e[34] ? d_rdata : if_rdata, e[31:0]);
        end
      end else begin
        check("misalign_idle", {31'h0, misalign}, 32'h0);
        check("bus_err_idle", {31'h0, bus_err}, 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  int          last_d_lat, last_f_lat;
  logic [31:0] last_d_rdata, last_f_rdata;
  logic        last_d_mis, last_d_berr;

  task automatic run_access(input bit do_f, input logic [31:0] f_addr, input int f_waits,
                            input logic [31:0] f_word,
                            input bit do_d, input logic we, input logic [2:0] typ,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int d_waits, input logic [31:0] d_word);
    bit d_ok, f_ok, d_to, f_to, d_seen, f_seen, done;
    int d_exp, f_exp, n;
    d_ok = (addr % nbytes(typ)) == 0;
    f_ok = (f_addr % 4) == 0;
    d_to = d_waits >= TIMEOUT;
    f_to = f_waits >= TIMEOUT;
    d_exp = !d_ok ? 1 : ((d_to ? TIMEOUT - 1 : d_waits) + 2);
    f_exp = !f_ok ? 1 : ((f_to ? TIMEOUT - 1 : f_waits) + 2);
    if (do_d && do_f) f_exp = d_exp + 1 + f_exp;
    if (do_d) begin
      if (d_ok)
        mem_q.push_back('{addr & ~32'h3, model_be(we, typ, addr), we, model_wdata(typ, wdata),
                          8'(d_waits), d_word});
      exp_q.push_back({1'b1, !d_ok, d_ok && d_to,
                       (d_ok && !d_to) ? model_load(typ, addr, d_word) : 32'h0});
    end
    if (do_f) begin
      if (f_ok)
        mem_q.push_back('{f_addr & ~32'h3, 4'hF, 1'b0, 32'h0, 8'(f_waits), f_word});
      exp_q.push_back({1'b0, !f_ok, f_ok && f_to, (f_ok && !f_to) ? f_word : 32'h0});
    end
    @(posedge clk); #1;
    if_req = do_f; if_addr = f_addr;
    d_req = do_d; d_we = we; d_type = typ; d_addr = addr; d_wdata = wdata;
    d_seen = 0; f_seen = 0; n = 0; done = 0;
    while (!done && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (d_seen) d_req = 1'b0;
      if (f_seen) if_req = 1'b0;
      if (d_req && d_valid && !d_seen) begin
        d_seen = 1; last_d_lat = n; last_d_rdata = d_rdata;
        last_d_mis = misalign; last_d_berr = bus_err;
      end
      if (if_req && if_valid && !f_seen) begin
        f_seen = 1; last_f_lat = n; last_f_rdata = if_rdata;
      end
      done = (!do_d || (d_seen && !d_req)) && (!do_f || (f_seen && !if_req));
    end
    if (!done) begin
      check("access_budget", n, 0);
      d_req = 1'b0; if_req = 1'b0;
      mem_q.delete(); exp_q.delete();
    end else begin
      if (do_d) check("d_latency", last_d_lat, d_exp);
      if (do_f) check("f_latency", last_f_lat, f_exp);
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_flags", {26'h0, if_valid, d_valid, misalign, bus_err, mem_req, mem_we}, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // zero-wait fetch
    run_access(1, 32'h0000_0010, 0, 32'h0051_8533, 0, 0, 3'b000, 0, 0, 0, 0);
    check("fetch_rdata_lit", last_f_rdata, 32'h0051_8533);
    check("fetch_lat_lit", last_f_lat, 2);
    check("fetch_addr_lit", last_addr, 32'h0000_0010);

    // store byte
    run_access(0, 0, 0, 0, 1, 1, 3'b011, 32'h103, 32'hAABB_CCDD, 0, 32'h1122_3344);
    check("sb_be_lit", {28'h0, last_be}, 32'h8);
    check("sb_wdata_lit", last_wdata, 32'hDDDD_DDDD);
    check("sb_addr_lit", last_addr, 32'h0000_0100);
    check("sb_we_lit", {31'h0, last_we}, 32'h1);

    // half loads, signed and unsigned
    run_access(0, 0, 0, 0, 1, 0, 3'b001, 32'h102, 0, 1, 32'h8001_7FFF);
    check("lh_lit", last_d_rdata, 32'hFFFF_8001);
    run_access(0, 0, 0, 0, 1, 0, 3'b010, 32'h102, 0, 0, 32'h8001_7FFF);
    check("lhu_lit", last_d_rdata, 32'h0000_8001);
    run_access(0, 0, 0, 0, 1, 0, 3'b001, 32'h100, 0, 3, 32'h8001_7FFF);
    check("lh_low_lit", last_d_rdata, 32'h0000_7FFF);

    // byte loads, stores of half and word
    run_access(0, 0, 0, 0, 1, 0, 3'b011, 32'h101, 0, 0, 32'h1234_8056);
    check("lb_lit", last_d_rdata, 32'hFFFF_FF80);
    run_access(0, 0, 0, 0, 1, 0, 3'b100, 32'h101, 0, 2, 32'h1234_8056);
    check("lbu_lit", last_d_rdata, 32'h0000_0080);
    run_access(0, 0, 0, 0, 1, 1, 3'b001, 32'h102, 32'h1234_ABCD, 1, 32'h0);
    check("sh_be_lit", {28'h0, last_be}, 32'hC);
    check("sh_wdata_lit", last_wdata, 32'hABCD_ABCD);
    run_access(0, 0, 0, 0, 1, 1, 3'b000, 32'h200, 32'hCAFE_F00D, 1, 32'h0);
    run_access(0, 0, 0, 0, 1, 0, 3'b000, 32'h204, 0, 0, 32'h7654_3210);

    // simultaneous: data first with 2 waits, fetch zero-wait after
    run_access(1, 32'h20, 0, 32'h0000_0013, 1, 0, 3'b000, 32'h40, 0, 2, 32'h5555_AAAA);
    check("both_d_lat_lit", last_d_lat, 4);
    check("both_f_gap_lit", last_f_lat - last_d_lat, 3);

    // misaligned accesses
    run_access(0, 0, 0, 0, 1, 0, 3'b000, 32'h6, 0, 0, 32'h1111_1111);
    check("mis_lat_lit", last_d_lat, 1);
    check("mis_flag_lit", {31'h0, last_d_mis}, 32'h1);
    check("mis_rdata_lit", last_d_rdata, 32'h0);
    run_access(0, 0, 0, 0, 1, 1, 3'b001, 32'h101, 32'hFFFF_FFFF, 0, 0);
    run_access(1, 32'h2, 0, 32'h1234_5678, 0, 0, 3'b000, 0, 0, 0, 0);

    // timeout, then a longest legal wait
    run_access(0, 0, 0, 0, 1, 0, 3'b000, 32'h80, 0, NEVER, 32'h9999_9999);
    check("to_lat_lit", last_d_lat, 17);
    check("to_berr_lit", {31'h0, last_d_berr}, 32'h1);
    run_access(1, 32'h84, TIMEOUT - 1, 32'hABCD_0123, 0, 0, 3'b000, 0, 0, 0, 0);
    check("slow_fetch_lit", last_f_rdata, 32'hABCD_0123);

    // reset during a data wait
    mem_q.push_back('{32'h300, 4'hF, 1'b0, 32'h0, 8'(NEVER), 32'h0});
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_type = 3'b000; d_addr = 32'h300;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_mid_state", {30'h0, dbg_state}, 32'h0);
    check("rst_mid_mem_req", {31'h0, mem_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_no_valid", {31'h0, d_valid}, 32'h0);
      @(posedge clk); #1;
    end

    // recovery after reset
    run_access(1, 32'h44, 1, 32'h0000_0073, 0, 0, 3'b000, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1);
  end

endmodule
